cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Synthesizable run controller for N MIPS cores, replacing free-running clock/reset benches.
- Sequences per-core reset hold and release, then counts run cycles.
- Detects per-core halt, either from an explicit halt flag or from a PC unchanged for a set number of cycles.
- Ends the run on all-halted or on a cycle-budget timeout, and reports status.
- Sits between the top-level bench/FPGA wrapper and the Mips core instances.

Parameters:
N_CORES, 1, number of supervised cores (channels)
PC_W, 32, PC width per core
CNT_W, 32, cycle counter width
RST_CYCLES, 2, cycles core_rst_n is held low after start (must be >= 1)
MAX_CYCLES, 50, run-cycle budget before timeout (must be >= 1 and < 2^CNT_W)
STALL_LIMIT, 4, consecutive unchanged-PC cycles that count as a halt; 0 disables stall detection

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low
start  in  1  begin a run; sampled only in IDLE or DONE
core_pc  in  N_CORES*PC_W  packed core PCs, core i at [i*PC_W +: PC_W]
core_halt  in  N_CORES  explicit halt flag per core
core_rst_n  out  N_CORES  per-core reset to the cores, active-low
running  out  1  high in RUN
cycle_cnt  out  CNT_W  completed RUN cycles of the current or last run
halted  out  N_CORES  sticky per-core halted flags
done  out  1  run finished, level
timeout  out  1  run ended by budget exhaustion, level

Behaviour:
Reset (rst=0 at an edge) applies regardless of state, including mid-run:
- state=IDLE, core_rst_n=0, running=0, cycle_cnt=0, halted=0, done=0, timeout=0.
- All stall counters and pc-valid flags are cleared.

FSM states: IDLE, RESET, RUN, DONE.
- IDLE: core_rst_n all 0. start=1 -> RESET; rst_cnt=0; clear cycle_cnt, halted, done, timeout.
- RESET: core_rst_n all 0; rst_cnt increments. When rst_cnt reaches RST_CYCLES-1 -> RUN. The low phase is exactly RST_CYCLES cycles.
- RUN: core_rst_n all 1, running=1. Each edge:
  - cycle_cnt += 1.
  - Per-core halt logic is evaluated (see below).
  - start is ignored.
- DONE: core_rst_n all 0 (cores frozen); done=1. All status outputs hold. start=1 -> RESET with the same clearing as in IDLE.

Per-core halt detection, RUN only; core i:
- core_halt[i]=1 -> halted[i] set at that edge.
- Stall detection (STALL_LIMIT > 0):
  - First RUN cycle: capture prev_pc[i] and set valid[i]; no compare.
  - Later cycles: if core_pc[i]==prev_pc[i], stall_cnt[i]+=1, else stall_cnt[i]=0. prev_pc[i] updates every cycle.
  - stall_cnt[i] reaching STALL_LIMIT sets halted[i].
- halted[i] is sticky until the next start or reset. Logic for a halted core is frozen.

Termination, evaluated at each RUN edge using next-state values:
- all_halted = AND of next halted[].
- all_halted -> DONE, timeout=0.
- Otherwise, if the next cycle_cnt == MAX_CYCLES -> DONE, timeout=1.
- If both occur on the same edge, halt wins: timeout=0.

Arithmetic and latency:
- cycle_cnt never exceeds MAX_CYCLES, so no wrap occurs.
- Latency from start to first core_rst_n=1 cycle: RST_CYCLES+1 edges.
- done and timeout are registered; they assert in the first DONE cycle.

Decomposition:
- Shared package cpu_run_pkg holds:
  - run-state enum (IDLE, RESET, RUN, DONE);
  - default constants DEF_MAX_CYCLES=50 and DEF_RST_CYCLES=2.
- One natural sub-module, halt_detect: per-core prev_pc, stall_cnt, valid and sticky halted logic.
  - Parameters: PC_W, STALL_LIMIT.
  - Instantiated N_CORES times in a generate loop.
- The top holds the FSM, rst_cnt, cycle_cnt and the termination logic.

Test Plan:
- N=1, RST_CYCLES=2: rst=0 one edge, start pulse.
  - Required: core_rst_n low for exactly 2 cycles, then 1; running=1; cycle_cnt=0,1,2 on successive edges.
- N=1, STALL_LIMIT=4: PC sequence 0,4,8,12, then held at 12.
  - Required: halted[0]=1 on the 4th repeated-PC edge, then DONE with done=1, timeout=0, core_rst_n=0; cycle_cnt frozen.
- N=1, MAX_CYCLES=50: PC increments by 4 every cycle, core_halt=0.
  - Required: done=1, timeout=1, cycle_cnt=50.
- Same-edge conflict: core_halt asserted on the edge where cycle_cnt goes 49 -> 50.
  - Required: done=1, timeout=0, halted[0]=1.
- N=2: core_halt[1] at cycle 10, core 0 PC stalls from cycle 20, STALL_LIMIT=4.
  - Required: halted=2'b10 from cycle 10; DONE only at cycle 24 with halted=2'b11.
- rst=0 at cycle 7 of RUN.
  - Required: next cycle IDLE, all outputs at reset values.
  - A subsequent start gives a full RESET phase, and cycle_cnt restarts at 0.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// Purpose : shared types and defaults for the multi-core run controller.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package cpu_run_pkg;

    // Run sequencing states: idle, reset hold, running, finished.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } run_state_e;

    localparam int DEF_MAX_CYCLES = 50;
    localparam int DEF_RST_CYCLES = 2;

endpackage

// File: rtl/cpu_run_ctrl_halt_detect.sv
// Purpose : per-core halt detector; explicit halt flag or PC unchanged STALL_LIMIT cycles.
// Latency : halted_o registers at the edge the condition is seen; halted_nxt_o is its D input.
// Backpressure: none; evaluates every RUN cycle, frozen once the core is halted.
//
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   clr_i          start of a new run: clear all per-core state
//   run_i          controller is in RUN
//   pc_i, halt_i   this core's PC and explicit halt flag
//   halted_o       sticky halted flag (registered)
//   halted_nxt_o   next-state halted flag, used for same-edge termination
module halt_detect #(
    parameter int PC_W        = 32,
    parameter int STALL_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            run_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic            halt_i,
    output logic            halted_o,
    output logic            halted_nxt_o
);

    localparam int SC_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);

    logic [PC_W-1:0] prev_pc_q, prev_pc_d;
    logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;
    logic            valid_q, valid_d;
    logic            halted_q, halted_d;

    always_comb begin
        prev_pc_d   = prev_pc_q;
        stall_cnt_d = stall_cnt_q;
        valid_d     = valid_q;
        halted_d    = halted_q;
        if (clr_i) begin
            prev_pc_d   = '0;
            stall_cnt_d = '0;
            valid_d     = 1'b0;
            halted_d    = 1'b0;
        end else if (run_i && !halted_q) begin
            if (halt_i) begin
                halted_d = 1'b1;
            end
            if (STALL_LIMIT > 0) begin
                prev_pc_d = pc_i;
                valid_d   = 1'b1;
                // The first RUN cycle only captures a reference PC.
                if (valid_q) begin
                    if (pc_i == prev_pc_q) begin
                        stall_cnt_d = stall_cnt_q + SC_W'(1);
                    end else begin
                        stall_cnt_d = '0;
                    end
                    if (stall_cnt_d == SC_W'(STALL_LIMIT)) begin
                        halted_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_pc_q   <= '0;
            stall_cnt_q <= '0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            prev_pc_q   <= prev_pc_d;
            stall_cnt_q <= stall_cnt_d;
            valid_q     <= valid_d;
            halted_q    <= halted_d;
        end
    end

    assign halted_o     = halted_q;
    assign halted_nxt_o = halted_d;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Purpose : run controller for N cores: reset hold/release, run-cycle count, halt/timeout end.
// Latency : start -> first core_rst_n=1 cycle in RST_CYCLES+1 edges; done/timeout registered.
// Backpressure: none; start is only honoured in IDLE or DONE.
//
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   start        begin a run (IDLE/DONE only)
//   core_pc      packed per-core PCs, core i at [i*PC_W +: PC_W]
//   core_halt    per-core explicit halt flags
//   core_rst_n   per-core active-low reset, released only in RUN
//   running      high in RUN
//   cycle_cnt    completed RUN cycles of the current/last run
//   halted       sticky per-core halted flags
//   done         run finished (level)
//   timeout      run ended by budget exhaustion (level)
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int N_CORES     = 1,
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter int STALL_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N_CORES*PC_W-1:0] core_pc,
    input  logic [N_CORES-1:0]      core_halt,
    output logic [N_CORES-1:0]      core_rst_n,
    output logic                    running,
    output logic [CNT_W-1:0]        cycle_cnt,
    output logic [N_CORES-1:0]      halted,
    output logic                    done,
    output logic                    timeout
);

    localparam int RC_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);

    run_state_e       state_q, state_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;

    logic               clr;
    logic               run_en;
    logic [N_CORES-1:0] halted_nxt;
    logic               all_halted;

    assign run_en     = (state_q == ST_RUN);
    assign clr        = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // Termination looks at next-state halted flags so a halt on the
    // budget edge is seen in the same cycle and wins over timeout.
    assign all_halted = &halted_nxt;

    for (genvar i = 0; i < N_CORES; i++) begin : g_core
        halt_detect #(
            .PC_W        (PC_W),
            .STALL_LIMIT (STALL_LIMIT)
        ) u_halt_detect (
            .clk          (clk),
            .rst          (rst),
            .clr_i        (clr),
            .run_i        (run_en),
            .pc_i         (core_pc[i*PC_W +: PC_W]),
            .halt_i       (core_halt[i]),
            .halted_o     (halted[i]),
            .halted_nxt_o (halted_nxt[i])
        );
    end

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RESET;
                    rst_cnt_d   = '0;
                    cycle_cnt_d = '0;
                    done_d      = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            ST_RESET: begin
                if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            ST_RUN: begin
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                if (all_halted) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
                end else if (cycle_cnt_d == CNT_W'(MAX_CYCLES)) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rst_cnt_q   <= '0;
            cycle_cnt_q <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign core_rst_n = {N_CORES{run_en}};
    assign running    = run_en;
    assign cycle_cnt  = cycle_cnt_q;
    assign done       = done_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Purpose : self-checking bench for cpu_run_ctrl (1-core and 2-core instances).
// Latency : n/a.
// Backpressure: n/a.
module tb_cpu_run_ctrl;

    typedef struct packed {
        logic [1:0]  crn;
        logic        running;
        logic [31:0] cnt;
        logic [1:0]  hlt;
        logic        done;
        logic        to;
    } obs_t;

    typedef struct packed {
        logic        rst;
        logic        start;
        logic        halt;
        logic [31:0] pc;
        obs_t        exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    = 1'b0;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic [31:0] pc1    = '0;
    logic [63:0] pc2    = '0;
    logic        halt1  = 1'b0;
    logic [1:0]  halt2  = '0;

    logic [0:0]  crn1, hlt1;
    logic        run1, done1, to1;
    logic [31:0] cnt1;
    logic [1:0]  crn2, hlt2;
    logic        run2, done2, to2;
    logic [31:0] cnt2;

    cpu_run_ctrl #(
        .N_CORES(1), .PC_W(32), .CNT_W(32),
        .RST_CYCLES(2), .MAX_CYCLES(50), .STALL_LIMIT(4)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .core_pc(pc1), .core_halt(halt1),
        .core_rst_n(crn1), .running(run1), .cycle_cnt(cnt1), .halted(hlt1),
        .done(done1), .timeout(to1)
    );

    cpu_run_ctrl #(
        .N_CORES(2), .PC_W(32), .CNT_W(32),
        .RST_CYCLES(2), .MAX_CYCLES(50), .STALL_LIMIT(4)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .core_pc(pc2), .core_halt(halt2),
        .core_rst_n(crn2), .running(run2), .cycle_cnt(cnt2), .halted(hlt2),
        .done(done2), .timeout(to2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    obs_t  exp_q[$];
    string nm_q[$];
    vec_t  vt[13];

    function automatic obs_t mk(input logic [1:0] crn, input logic r, input int cnt,
                                input logic [1:0] h, input logic d, input logic t);
        obs_t o;
        o.crn     = crn;
        o.running = r;
        o.cnt     = 32'(cnt);
        o.hlt     = h;
        o.done    = d;
        o.to      = t;
        return o;
    endfunction

    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel == 1) begin
            o = mk({1'b0, crn1}, run1, int'(cnt1), {1'b0, hlt1}, done1, to1);
        end else begin
            o = mk(crn2, run2, int'(cnt2), hlt2, done2, to2);
        end
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("crn=%b run=%b cnt=%0d halted=%b done=%b timeout=%b",
                         o.crn, o.running, o.cnt, o.hlt, o.done, o.to);
    endfunction

    // Push expectation, clock once, then pop and compare against the DUT.
    task automatic cyc(input int sel, input string nm, input obs_t e);
        obs_t  a;
        obs_t  x;
        string n;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
        a = sample(sel);
        x = exp_q.pop_front();
        n = nm_q.pop_front();
        n_chk++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s", n, fmt(a), fmt(x));
        end
    endtask

    // Start pulse plus the two-cycle reset hold, landing in the first RUN cycle.
    task automatic start_run1(input string tag);
        start1 = 1'b1;
        halt1  = 1'b0;
        cyc(1, {tag, "_rst0"}, mk(2'b00, 1'b0, 0, 2'b00, 1'b0, 1'b0));
        start1 = 1'b0;
        cyc(1, {tag, "_rst1"}, mk(2'b00, 1'b0, 0, 2'b00, 1'b0, 1'b0));
        cyc(1, {tag, "_run0"}, mk(2'b01, 1'b1, 0, 2'b00, 1'b0, 1'b0));
    endtask

    initial begin
        obs_t idle1;
        idle1 = mk(2'b00, 1'b0, 0, 2'b00, 1'b0, 1'b0);

        // Reset, start, reset hold, then PC 0,4,8,12 held at 12 until stall halt.
        vt[0]  = '{1'b0, 1'b0, 1'b0, 32'd0,  idle1};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 32'd0,  idle1};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 32'd0,  idle1};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 32'd0,  mk(2'b01, 1'b1, 0, 2'b00, 1'b0, 1'b0)};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 32'd0,  mk(2'b01, 1'b1, 1, 2'b00, 1'b0, 1'b0)};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 32'd4,  mk(2'b01, 1'b1, 2, 2'b00, 1'b0, 1'b0)};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 32'd8,  mk(2'b01, 1'b1, 3, 2'b00, 1'b0, 1'b0)};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 32'd12, mk(2'b01, 1'b1, 4, 2'b00, 1'b0, 1'b0)};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 32'd12, mk(2'b01, 1'b1, 5, 2'b00, 1'b0, 1'b0)};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 32'd12, mk(2'b01, 1'b1, 6, 2'b00, 1'b0, 1'b0)};
        vt[10] = '{1'b1, 1'b0, 1'b0, 32'd12, mk(2'b01, 1'b1, 7, 2'b00, 1'b0, 1'b0)};
        vt[11] = '{1'b1, 1'b0, 1'b0, 32'd12, mk(2'b00, 1'b0, 8, 2'b01, 1'b1, 1'b0)};
        vt[12] = '{1'b1, 1'b0, 1'b0, 32'd40, mk(2'b00, 1'b0, 8, 2'b01, 1'b1, 1'b0)};

        for (int i = 0; i < 13; i++) begin
            rst    = vt[i].rst;
            start1 = vt[i].start;
            halt1  = vt[i].halt;
            pc1    = vt[i].pc;
            cyc(1, $sformatf("tbl[%0d]", i), vt[i].exp);
        end

        // Budget timeout: PC always advancing; a mid-run start must be ignored.
        start_run1("to");
        for (int c = 0; c < 50; c++) begin
            pc1    = 32'(4 * c);
            start1 = (c == 10);
            cyc(1, $sformatf("to_c%0d", c),
                (c == 49) ? mk(2'b00, 1'b0, 50, 2'b00, 1'b1, 1'b1)
                          : mk(2'b01, 1'b1, c + 1, 2'b00, 1'b0, 1'b0));
        end
        start1 = 1'b0;
        cyc(1, "to_hold", mk(2'b00, 1'b0, 50, 2'b00, 1'b1, 1'b1));

        // Explicit halt on the same edge the budget runs out: halt wins.
        start_run1("cf");
        for (int c = 0; c < 50; c++) begin
            pc1   = 32'(4 * c);
            halt1 = (c == 49);
            cyc(1, $sformatf("cf_c%0d", c),
                (c == 49) ? mk(2'b00, 1'b0, 50, 2'b01, 1'b1, 1'b0)
                          : mk(2'b01, 1'b1, c + 1, 2'b00, 1'b0, 1'b0));
        end
        halt1 = 1'b0;
        cyc(1, "cf_hold", mk(2'b00, 1'b0, 50, 2'b01, 1'b1, 1'b0));

        // Reset mid-run, then a fresh run restarts from a full reset phase.
        start_run1("mr");
        for (int c = 0; c < 7; c++) begin
            pc1 = 32'(4 * c);
            cyc(1, $sformatf("mr_c%0d", c), mk(2'b01, 1'b1, c + 1, 2'b00, 1'b0, 1'b0));
        end
        rst = 1'b0;
        cyc(1, "mr_rst", idle1);
        rst = 1'b1;
        cyc(1, "mr_idle", idle1);
        start_run1("mr2");
        pc1 = 32'd0;
        cyc(1, "mr2_c0", mk(2'b01, 1'b1, 1, 2'b00, 1'b0, 1'b0));

        // Two cores: core 1 halts by flag at cycle 10, core 0 stalls from cycle 20.
        start2 = 1'b1;
        cyc(2, "n2_rst0", mk(2'b00, 1'b0, 0, 2'b00, 1'b0, 1'b0));
        start2 = 1'b0;
        cyc(2, "n2_rst1", mk(2'b00, 1'b0, 0, 2'b00, 1'b0, 1'b0));
        cyc(2, "n2_run0", mk(2'b11, 1'b1, 0, 2'b00, 1'b0, 1'b0));
        for (int c = 0; c < 24; c++) begin
            pc2   = {32'(4 * c), 32'(4 * ((c < 19) ? c : 19))};
            halt2 = {(c == 10), 1'b0};
            cyc(2, $sformatf("n2_c%0d", c),
                (c == 23) ? mk(2'b00, 1'b0, 24, 2'b11, 1'b1, 1'b0)
                          : mk(2'b11, 1'b1, c + 1, (c >= 10) ? 2'b10 : 2'b00, 1'b0, 1'b0));
        end
        halt2 = 2'b00;
        cyc(2, "n2_hold", mk(2'b00, 1'b0, 24, 2'b11, 1'b1, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
